// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the serial frame receive controller.
// Holds the FSM state encoding and the default bit timing / frame width.
package serial_rx_pkg;

    localparam int unsigned DIVISOR_DEFAULT   = 500;
    localparam int unsigned DATA_BITS_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/bit_tick_counter.sv
// Loadable down-counter that produces a clock-enable tick for mid-bit sampling.
// It parks at zero (tick held) until the controller reloads it.
module bit_tick_counter #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick is a pure decode of the count register, so it is glitch-free.
    assign tick = (cnt_q == '0);

endmodule

// File: rtl/serial_frame_rx_ctrl.sv
// Serial frame receiver: start detect, mid-bit sampling, stop check and
// valid/ready presentation of the captured frame (first bit at MSB).
module serial_frame_rx_ctrl
    import serial_rx_pkg::*;
#(
    parameter int unsigned DIVISOR   = DIVISOR_DEFAULT,
    parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned CNT_W = $clog2(DIVISOR);
    localparam int unsigned BC_W  = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIVISOR - 1);
    localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(DATA_BITS - 1);

    rx_state_e state_q, state_d;

    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic             tick;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;

    // Two-flop synchronizer; idle line level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= data_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    bit_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .tick     (tick)
    );

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q && !out_ready;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = FULL_LOAD;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d      = START;
                    cnt_load     = 1'b1;
                    cnt_load_val = HALF_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        cnt_load  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sr_d      = DATA_BITS'({sr_q, rx_s_q});
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    cnt_load  = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    if (rx_s_q) begin
                        // A pending frame may be replaced only if accepted in this same cycle.
                        if (!out_valid_q || out_ready) begin
                            out_data_d  = sr_q;
                            out_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
